mux_arb_m: RTL and testbench

Registered N-channel successor to the 2:1 combinational mux. It selects one of CHANNELS input streams of WIDTH bits and delivers it through a single output register with valid/ready handshakes on both sides. It has two modes: fixed select (the 2:1 mux behaviour, generalised) and round-robin arbitration. It sits between multiple producers and one consumer, so the consumer can stall without data loss.

---
 rtl/mux_arb_m.sv | 102 ++++++++++
 tb/tb_mux_arb_m.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/mux_arb_m.sv
// N-channel registered mux/arbiter: fixed-select or round-robin into one output register.
// Optional feature macro MUX_ARB_COUNT_EN adds a 16-bit output-transfer counter (xfer_cnt).
module mux_arb_m #(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned CHANNELS = 4,
   localparam int unsigned SELW    = $clog2(CHANNELS)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [CHANNELS*WIDTH-1:0] in_data,
   input  logic [CHANNELS-1:0]       in_valid,
   output logic [CHANNELS-1:0]       in_ready,
   input  logic                      mode,
   input  logic [SELW-1:0]           sel,
   output logic [WIDTH-1:0]          out_data,
   output logic [SELW-1:0]           out_chan,
   output logic                      out_valid,
   input  logic                      out_ready
`ifdef MUX_ARB_COUNT_EN
   ,
   output logic [15:0]               xfer_cnt
`endif
);

   localparam int unsigned CNTW = 16;

   logic            load_en;
   logic            grant_vld;
   logic [SELW-1:0] grant;
   logic [SELW-1:0] ptr;
   logic            in_xfer;

   // Channel reached after stepping k places upward from base, modulo CHANNELS.
   function automatic logic [SELW-1:0] step_idx(input logic [SELW-1:0] base,
                                                input int unsigned     k);
      int unsigned sum;
      sum = (32'(base) + k) % CHANNELS;
      return SELW'(sum);
   endfunction

   assign load_en = !out_valid || out_ready;

   // Grant selection; round-robin walks down so the nearest requester after ptr wins.
   always_comb begin
      grant_vld = 1'b0;
      grant     = '0;
      if (!mode) begin
         for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (sel == SELW'(i) && in_valid[i]) begin
               grant_vld = 1'b1;
               grant     = SELW'(i);
            end
         end
      end else begin
         for (int unsigned k = CHANNELS; k >= 1; k--) begin
            if (in_valid[step_idx(ptr, k)]) begin
               grant_vld = 1'b1;
               grant     = step_idx(ptr, k);
            end
         end
      end
   end

   always_comb begin
      in_ready = '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         in_ready[i] = load_en && grant_vld && (grant == SELW'(i));
      end
   end

   assign in_xfer = load_en && grant_vld;

   // Output register and fairness pointer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_chan  <= '0;
         ptr       <= SELW'(CHANNELS - 1);
      end else if (load_en) begin
         out_valid <= grant_vld;
         if (grant_vld) begin
            out_data <= in_data[32'(grant)*WIDTH +: WIDTH];
            out_chan <= grant;
            ptr      <= grant;
         end
      end
   end

`ifdef MUX_ARB_COUNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         xfer_cnt <= '0;
      end else if (out_valid && out_ready) begin
         xfer_cnt <= xfer_cnt + CNTW'(1);
      end
   end
`else
   localparam int unsigned UNUSED_CNTW = CNTW;
`endif

endmodule

// File: tb/tb_mux_arb_m.sv
// Directed vector bench for mux_arb_m (4 channels x 8 bits), plus reset and counter sequences.
module tb_mux_arb_m;

   localparam int unsigned WIDTH    = 8;
   localparam int unsigned CHANNELS = 4;
   localparam int unsigned SELW     = 2;

   logic                      clk = 1'b0;
   logic                      rst_n = 1'b0;
   logic [CHANNELS*WIDTH-1:0] in_data;
   logic [CHANNELS-1:0]       in_valid = '0;
   logic [CHANNELS-1:0]       in_ready;
   logic                      mode = 1'b0;
   logic [SELW-1:0]           sel = '0;
   logic [WIDTH-1:0]          out_data;
   logic [SELW-1:0]           out_chan;
   logic                      out_valid;
   logic                      out_ready = 1'b0;
`ifdef MUX_ARB_COUNT_EN
   logic [15:0]               xfer_cnt;
`endif

   mux_arb_m #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
      .out_chan(out_chan), .out_valid(out_valid), .out_ready(out_ready)
`ifdef MUX_ARB_COUNT_EN
      , .xfer_cnt(xfer_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic            mode;
      logic [SELW-1:0] sel;
      logic [3:0]      in_valid;
      logic            out_ready;
      logic [3:0]      exp_ready;
      logic            exp_ov;
      logic [7:0]      exp_od;
      logic [SELW-1:0] exp_oc;
   } vec_t;

   vec_t vecs[$];
   int   n_vec = 0;
   int   n_bad = 0;

   task automatic add(input logic m, input logic [1:0] s, input logic [3:0] iv,
                      input logic r, input logic [3:0] er, input logic ov,
                      input logic [7:0] od, input logic [1:0] oc);
      vec_t v;
      v.mode = m; v.sel = s; v.in_valid = iv; v.out_ready = r;
      v.exp_ready = er; v.exp_ov = ov; v.exp_od = od; v.exp_oc = oc;
      vecs.push_back(v);
   endtask

   task automatic chk_ready(input string name, input logic [3:0] exp);
      n_vec++;
      if (in_ready !== exp) begin
         n_bad++;
         $display("FAIL %s in_ready got %b want %b", name, in_ready, exp);
      end
   endtask

   task automatic chk_out(input string name, input logic ov, input logic [7:0] od,
                          input logic [1:0] oc);
      n_vec++;
      if (out_valid !== ov || out_data !== od || out_chan !== oc) begin
         n_bad++;
         $display("FAIL %s out v/d/c got %b/%h/%0d want %b/%h/%0d",
                  name, out_valid, out_data, out_chan, ov, od, oc);
      end
   endtask

   initial begin
      in_data = {8'hFF, 8'hAA, 8'h55, 8'h00};

      // fixed select, all valid
      add(0, 0, 4'b1111, 1, 4'b0001, 1, 8'h00, 0);
      add(0, 1, 4'b1111, 1, 4'b0010, 1, 8'h55, 1);
      add(0, 2, 4'b1111, 1, 4'b0100, 1, 8'hAA, 2);
      add(0, 3, 4'b1111, 1, 4'b1000, 1, 8'hFF, 3);
      // selected channel not valid: no grant, output drains, data holds
      add(0, 2, 4'b1011, 1, 4'b0000, 0, 8'hFF, 3);
      // round-robin, all valid, wrap from ptr=3
      add(1, 0, 4'b1111, 1, 4'b0001, 1, 8'h00, 0);
      add(1, 0, 4'b1111, 1, 4'b0010, 1, 8'h55, 1);
      add(1, 0, 4'b1111, 1, 4'b0100, 1, 8'hAA, 2);
      add(1, 0, 4'b1111, 1, 4'b1000, 1, 8'hFF, 3);
      add(1, 0, 4'b1111, 1, 4'b0001, 1, 8'h00, 0);
      add(1, 0, 4'b1111, 1, 4'b0010, 1, 8'h55, 1);
      // round-robin, sparse
      add(1, 0, 4'b1010, 1, 4'b1000, 1, 8'hFF, 3);
      add(1, 0, 4'b1010, 1, 4'b0010, 1, 8'h55, 1);
      add(1, 0, 4'b1010, 1, 4'b1000, 1, 8'hFF, 3);
      add(1, 0, 4'b1010, 1, 4'b0010, 1, 8'h55, 1);
      // backpressure holding 8'h55
      add(1, 0, 4'b1111, 0, 4'b0000, 1, 8'h55, 1);
      add(1, 0, 4'b1111, 0, 4'b0000, 1, 8'h55, 1);
      add(1, 0, 4'b1111, 0, 4'b0000, 1, 8'h55, 1);
      // release: 55 consumed and next grant (ch2) loaded same cycle
      add(1, 0, 4'b1111, 1, 4'b0100, 1, 8'hAA, 2);
      add(1, 0, 4'b0000, 0, 4'b0000, 1, 8'hAA, 2);
      add(1, 0, 4'b0000, 1, 4'b0000, 0, 8'hAA, 2);
      // fixed-select grant updates ptr, round-robin continues from it
      add(0, 0, 4'b1111, 1, 4'b0001, 1, 8'h00, 0);
      add(1, 0, 4'b1111, 1, 4'b0010, 1, 8'h55, 1);

      #12;
      chk_ready("reset_in_ready", 4'b0000);
      chk_out("reset_out", 0, 8'h00, 0);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      foreach (vecs[i]) begin
         mode = vecs[i].mode; sel = vecs[i].sel;
         in_valid = vecs[i].in_valid; out_ready = vecs[i].out_ready;
         #1 chk_ready($sformatf("vec%0d", i), vecs[i].exp_ready);
         @(posedge clk); #1;
         chk_out($sformatf("vec%0d", i), vecs[i].exp_ov, vecs[i].exp_od, vecs[i].exp_oc);
      end

      // asynchronous reset while out_valid=1
      rst_n = 1'b0;
      #1 chk_out("async_reset", 0, 8'h00, 0);
      #2 rst_n = 1'b1;
      mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
      #1 chk_ready("post_reset_grant", 4'b0001);
      @(posedge clk); #1;
      chk_out("post_reset_out", 1, 8'h00, 0);

`ifdef MUX_ARB_COUNT_EN
      n_vec++;
      if (xfer_cnt !== 16'd0) begin
         n_bad++;
         $display("FAIL cnt_start got %0d want 0", xfer_cnt);
      end
      repeat (10) @(posedge clk);
      #1 n_vec++;
      if (xfer_cnt !== 16'd10) begin
         n_bad++;
         $display("FAIL cnt_10 got %0d want 10", xfer_cnt);
      end
      repeat (65526) @(posedge clk);
      #1 n_vec++;
      if (xfer_cnt !== 16'd0) begin
         n_bad++;
         $display("FAIL cnt_wrap got %0d want 0", xfer_cnt);
      end
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
